// File: rtl/mem_wb_unit_pkg.sv
// Shared types for the memory-access / write-back stage: op codes, FSM states
// and small helpers that classify an op and give its access size.
package mem_wb_unit_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int REG_W      = 32;
    localparam int BYTE_W     = 8;

    typedef enum logic [3:0] {
        MEM_NONE = 4'd0,
        MEM_LB   = 4'd1,
        MEM_LH   = 4'd2,
        MEM_LW   = 4'd3,
        MEM_LBU  = 4'd4,
        MEM_LHU  = 4'd5,
        MEM_SB   = 4'd6,
        MEM_SH   = 4'd7,
        MEM_SW   = 4'd8
    } mem_op_e;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_LWAIT = 3'd2,
        ST_STORE = 3'd3,
        ST_DONE  = 3'd4
    } state_e;

    function automatic logic is_load(input logic [3:0] op);
        return (op == MEM_LB) || (op == MEM_LH) || (op == MEM_LW) ||
               (op == MEM_LBU) || (op == MEM_LHU);
    endfunction

    function automatic logic is_store(input logic [3:0] op);
        return (op == MEM_SB) || (op == MEM_SH) || (op == MEM_SW);
    endfunction

    // Index of the last byte of the access (access size minus one).
    function automatic logic [1:0] last_idx(input logic [3:0] op);
        case (op)
            MEM_LH, MEM_LHU, MEM_SH: return 2'd1;
            MEM_LW, MEM_SW:          return 2'd3;
            default:                 return 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/mem_load_ext.sv
// Combinational load extension: turns assembled little-endian bytes into the
// register value, sign-extending LB/LH and zero-extending LBU/LHU.
module mem_load_ext
    import mem_wb_unit_pkg::*;
(
    input  logic [REG_W-1:0] raw,
    input  logic [3:0]       op,
    output logic [REG_W-1:0] result
);

    always_comb begin
        case (op)
            MEM_LB:  result = {{24{raw[7]}}, raw[7:0]};
            MEM_LH:  result = {{16{raw[15]}}, raw[15:0]};
            MEM_LBU: result = {24'd0, raw[7:0]};
            MEM_LHU: result = {16'd0, raw[15:0]};
            default: result = raw;
        endcase
    end

endmodule

// File: rtl/mem_wb_unit.sv
// MEM/WB stage: ALU results pass through with one cycle of latency, loads and
// stores are serialised byte by byte over the RAM port while the pipeline stalls.
module mem_wb_unit
    import mem_wb_unit_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    input  logic [REG_ADDR_W-1:0] in_wd,
    input  logic                  in_wreg,
    input  logic [REG_W-1:0]      in_wdata,
    input  logic [3:0]            in_mem_op,
    input  logic [ADDR_W-1:0]     in_mem_addr,
    input  logic [REG_W-1:0]      in_store_data,
    output logic [ADDR_W-1:0]     mem_a,
    output logic [BYTE_W-1:0]     mem_dout,
    output logic                  mem_wr,
    input  logic [BYTE_W-1:0]     mem_din,
    output logic                  stall_req,
    output logic [REG_ADDR_W-1:0] waddr,
    output logic [REG_W-1:0]      wdata,
    output logic                  we
);

    state_e                state;
    logic [1:0]            cnt;
    logic [3:0]            op_q;
    logic [REG_ADDR_W-1:0] wd_q;
    logic                  wreg_q;
    logic [ADDR_W-1:0]     addr_q;
    logic [REG_W-1:0]      sdata_q;
    logic [REG_W-1:0]      asm_q;

    logic [1:0]            cap_idx;
    logic [1:0]            cnt_nxt;
    logic [REG_W-1:0]      asm_cap;
    logic [REG_W-1:0]      load_val;
    logic [ADDR_W-1:0]     next_a;
    logic                  accept_mem;

    assign accept_mem = in_valid && (is_load(in_mem_op) || is_store(in_mem_op));

    // stall_req is raised combinationally in the accept cycle so upstream holds.
    assign stall_req = (state == ST_LOAD) || (state == ST_LWAIT) || (state == ST_STORE) ||
                       ((state == ST_IDLE) && accept_mem);

    assign cnt_nxt = cnt + 2'd1;
    assign next_a  = addr_q + ADDR_W'(cnt_nxt);

    // Read data lags the address by one cycle, so LOAD captures byte cnt-1
    // while LWAIT captures the final byte cnt.
    // NOTE: every signal assigned here gets a default first so no latch is inferred.
    always_comb begin
        cap_idx = (state == ST_LWAIT) ? cnt : cnt - 2'd1;
        asm_cap = asm_q;
        asm_cap[{cap_idx, 3'b000} +: 8] = mem_din;
    end

    mem_load_ext u_load_ext (
        .raw    (asm_cap),
        .op     (op_q),
        .result (load_val)
    );

    // NOTE: all state below uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            cnt      <= 2'd0;
            op_q     <= MEM_NONE;
            wd_q     <= '0;
            wreg_q   <= 1'b0;
            addr_q   <= '0;
            sdata_q  <= '0;
            asm_q    <= '0;
            mem_a    <= '0;
            mem_dout <= '0;
            mem_wr   <= 1'b0;
            waddr    <= '0;
            wdata    <= '0;
            we       <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    mem_wr <= 1'b0;
                    if (accept_mem) begin
                        op_q    <= in_mem_op;
                        wd_q    <= in_wd;
                        wreg_q  <= in_wreg;
                        addr_q  <= in_mem_addr;
                        sdata_q <= in_store_data;
                        mem_a   <= in_mem_addr;
                        cnt     <= 2'd0;
                        we      <= 1'b0;
                        if (is_load(in_mem_op)) begin
                            asm_q <= '0;
                            state <= ST_LOAD;
                        end else begin
                            mem_dout <= in_store_data[7:0];
                            mem_wr   <= 1'b1;
                            state    <= ST_STORE;
                        end
                    end else if (in_valid) begin
                        we    <= in_wreg && (in_wd != '0);
                        waddr <= in_wd;
                        wdata <= in_wdata;
                    end else begin
                        we <= 1'b0;
                    end
                end
                ST_LOAD: begin
                    if (cnt != 2'd0) asm_q <= asm_cap;
                    if (cnt == last_idx(op_q)) begin
                        state <= ST_LWAIT;
                    end else begin
                        cnt   <= cnt_nxt;
                        mem_a <= next_a;
                    end
                end
                ST_LWAIT: begin
                    asm_q <= asm_cap;
                    we    <= wreg_q && (wd_q != '0);
                    waddr <= wd_q;
                    wdata <= load_val;
                    state <= ST_DONE;
                end
                ST_STORE: begin
                    if (cnt == last_idx(op_q)) begin
                        mem_wr <= 1'b0;
                        state  <= ST_DONE;
                    end else begin
                        cnt      <= cnt_nxt;
                        mem_a    <= next_a;
                        mem_dout <= sdata_q[{cnt_nxt, 3'b000} +: 8];
                    end
                end
                ST_DONE: begin
                    we    <= 1'b0;
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_wb_unit.sv
// Directed bench for mem_wb_unit with a byte-wide RAM model whose read data
// arrives one cycle after the address.
module tb_mem_wb_unit;
    import mem_wb_unit_pkg::*;

    localparam int ADDR_W = 32;

    logic                  clk = 1'b0;
    logic                  rst;
    logic                  in_valid;
    logic [REG_ADDR_W-1:0] in_wd;
    logic                  in_wreg;
    logic [REG_W-1:0]      in_wdata;
    logic [3:0]            in_mem_op;
    logic [ADDR_W-1:0]     in_mem_addr;
    logic [REG_W-1:0]      in_store_data;
    logic [ADDR_W-1:0]     mem_a;
    logic [BYTE_W-1:0]     mem_dout;
    logic                  mem_wr;
    logic [BYTE_W-1:0]     mem_din;
    logic                  stall_req;
    logic [REG_ADDR_W-1:0] waddr;
    logic [REG_W-1:0]      wdata;
    logic                  we;

    logic                  pre_we;
    logic [9:0]            pre_a;
    logic [7:0]            pre_d;
    logic [7:0]            ram [0:1023];

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    mem_wb_unit #(.ADDR_W(ADDR_W)) dut (
        .clk           (clk),
        .rst           (rst),
        .in_valid      (in_valid),
        .in_wd         (in_wd),
        .in_wreg       (in_wreg),
        .in_wdata      (in_wdata),
        .in_mem_op     (in_mem_op),
        .in_mem_addr   (in_mem_addr),
        .in_store_data (in_store_data),
        .mem_a         (mem_a),
        .mem_dout      (mem_dout),
        .mem_wr        (mem_wr),
        .mem_din       (mem_din),
        .stall_req     (stall_req),
        .waddr         (waddr),
        .wdata         (wdata),
        .we            (we)
    );

    always @(posedge clk) begin
        if (mem_wr) ram[mem_a[9:0]] <= mem_dout;
        else if (pre_we) ram[pre_a] <= pre_d;
        mem_din <= ram[mem_a[9:0]];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic poke(input logic [9:0] a, input logic [7:0] d);
        pre_we = 1'b1;
        pre_a  = a;
        pre_d  = d;
        next_cycle();
        pre_we = 1'b0;
    endtask

    // Issues a load at cycle T and walks it through to write-back.
    task automatic run_load(input string tag, input logic [3:0] op, input logic [31:0] addr,
                            input logic [4:0] wd, input int n,
                            input logic exp_we, input logic [31:0] exp_data);
        in_valid    = 1'b1;
        in_mem_op   = op;
        in_mem_addr = addr;
        in_wd       = wd;
        in_wreg     = 1'b1;
        in_wdata    = 32'hDEADBEEF;
        #1;
        check({tag, " stall T"}, stall_req, 1'b1);
        for (int i = 0; i < n; i++) begin
            next_cycle();
            check($sformatf("%s mem_a T+%0d", tag, i + 1), mem_a, addr + i);
            check($sformatf("%s stall T+%0d", tag, i + 1), stall_req, 1'b1);
            check($sformatf("%s mem_wr T+%0d", tag, i + 1), mem_wr, 1'b0);
        end
        next_cycle();
        check({tag, " stall lwait"}, stall_req, 1'b1);
        check({tag, " we lwait"}, we, 1'b0);
        next_cycle();
        check({tag, " we done"}, we, exp_we);
        check({tag, " stall done"}, stall_req, 1'b0);
        if (exp_we) begin
            check({tag, " waddr"}, waddr, wd);
            check({tag, " wdata"}, wdata, exp_data);
        end
        in_valid = 1'b0;
        next_cycle();
        check({tag, " we after"}, we, 1'b0);
        check({tag, " stall after"}, stall_req, 1'b0);
    endtask

    initial begin
        rst           = 1'b1;
        in_valid      = 1'b0;
        in_wd         = '0;
        in_wreg       = 1'b0;
        in_wdata      = '0;
        in_mem_op     = MEM_NONE;
        in_mem_addr   = '0;
        in_store_data = '0;
        pre_we        = 1'b0;
        pre_a         = '0;
        pre_d         = '0;

        // RAM preload while the DUT sits in reset
        poke(10'h100, 8'h11);
        poke(10'h101, 8'h22);
        poke(10'h102, 8'h33);
        poke(10'h103, 8'h44);
        poke(10'h020, 8'h80);
        poke(10'h030, 8'h01);
        poke(10'h031, 8'h80);
        poke(10'h042, 8'h5A);

        check("rst we", we, 1'b0);
        check("rst waddr", waddr, 5'd0);
        check("rst wdata", wdata, 32'd0);
        check("rst mem_a", mem_a, 32'd0);
        check("rst mem_dout", mem_dout, 8'd0);
        check("rst mem_wr", mem_wr, 1'b0);
        check("rst stall", stall_req, 1'b0);

        // ALU pass-through, back to back
        rst      = 1'b0;
        in_valid = 1'b1;
        in_wreg  = 1'b1;
        in_wd    = 5'd5;
        in_wdata = 32'h1234;
        #1;
        check("alu stall A", stall_req, 1'b0);
        next_cycle();
        in_wd    = 5'd6;
        in_wdata = 32'hDEAD;
        #1;
        check("alu we 1", we, 1'b1);
        check("alu waddr 1", waddr, 5'd5);
        check("alu wdata 1", wdata, 32'h1234);
        check("alu stall B", stall_req, 1'b0);
        next_cycle();
        in_valid = 1'b0;
        check("alu we 2", we, 1'b1);
        check("alu waddr 2", waddr, 5'd6);
        check("alu wdata 2", wdata, 32'hDEAD);
        next_cycle();
        check("alu idle we", we, 1'b0);

        run_load("lw", MEM_LW, 32'h100, 5'd7, 4, 1'b1, 32'h44332211);
        run_load("lb", MEM_LB, 32'h20, 5'd8, 1, 1'b1, 32'hFFFFFF80);
        run_load("lbu", MEM_LBU, 32'h20, 5'd9, 1, 1'b1, 32'h00000080);
        run_load("lh", MEM_LH, 32'h30, 5'd10, 2, 1'b1, 32'hFFFF8001);
        run_load("lw x0", MEM_LW, 32'h100, 5'd0, 4, 1'b0, 32'h0);

        // SH: two byte writes, no register write
        in_valid      = 1'b1;
        in_mem_op     = MEM_SH;
        in_mem_addr   = 32'h40;
        in_store_data = 32'hAABBCCDD;
        in_wd         = 5'd3;
        in_wreg       = 1'b0;
        #1;
        check("sh stall T", stall_req, 1'b1);
        next_cycle();
        check("sh wr T+1", mem_wr, 1'b1);
        check("sh a T+1", mem_a, 32'h40);
        check("sh dout T+1", mem_dout, 8'hDD);
        check("sh stall T+1", stall_req, 1'b1);
        check("sh we T+1", we, 1'b0);
        next_cycle();
        check("sh wr T+2", mem_wr, 1'b1);
        check("sh a T+2", mem_a, 32'h41);
        check("sh dout T+2", mem_dout, 8'hCC);
        check("sh stall T+2", stall_req, 1'b1);
        next_cycle();
        check("sh stall T+3", stall_req, 1'b0);
        check("sh wr T+3", mem_wr, 1'b0);
        check("sh we T+3", we, 1'b0);
        check("sh a hold", mem_a, 32'h41);
        in_valid = 1'b0;
        next_cycle();
        check("sh ram 40", ram[10'h040], 8'hDD);
        check("sh ram 41", ram[10'h041], 8'hCC);
        check("sh ram 42", ram[10'h042], 8'h5A);
        check("sh we idle", we, 1'b0);

        // Reset in T+2 of a LW aborts it
        in_valid    = 1'b1;
        in_mem_op   = MEM_LW;
        in_mem_addr = 32'h100;
        in_wd       = 5'd7;
        in_wreg     = 1'b1;
        next_cycle();
        next_cycle();
        rst      = 1'b1;
        in_valid = 1'b0;
        next_cycle();
        rst = 1'b0;
        #1;
        check("abort stall", stall_req, 1'b0);
        check("abort we", we, 1'b0);
        check("abort mem_wr", mem_wr, 1'b0);
        check("abort mem_a", mem_a, 32'd0);
        next_cycle();
        check("abort idle we", we, 1'b0);
        in_valid  = 1'b1;
        in_mem_op = MEM_NONE;
        in_wd     = 5'd9;
        in_wdata  = 32'h55;
        #1;
        check("post alu stall", stall_req, 1'b0);
        next_cycle();
        in_valid = 1'b0;
        check("post alu we", we, 1'b1);
        check("post alu waddr", waddr, 5'd9);
        check("post alu wdata", wdata, 32'h55);
        next_cycle();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
